alu_accum_top: RTL
==================

# alu_accum_top

Parametrised successor of the board-level ALU top. It registers operands and opcode from slide switches under debounced, edge-detected push-button control, and computes a registered result with overflow and zero flags. An optional accumulate button chains the result back into operand A. It sits directly under the FPGA board wrapper and drives the LEDs.

## Interface
- `N`, default 5: operand/result width, 2..16.
- `NSel`, default 6: opcode width, at least 6.
- `N_SW`, default `(2*N)+NSel`: switch bus width. Elaboration fails if `N_SW > 16`.
- `SYNC_STAGES`, default 2: button synchroniser depth, at least 2.
- `i_clock`, in, 1: sole clock.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_switches`, in, `N_SW`: field A = `[N-1:0]`, field B = `[2N-1:N]`, field Op = `[N_SW-1:2N]`.
- `i_button_A`, in, 1: raw, asynchronous; load A.
- `i_button_B`, in, 1: raw; load B.
- `i_button_Op`, in, 1: raw; load opcode.
- `i_button_Acc`, in, 1: raw; copy result into A. Present only with `ALU_ACCUM_EN`.
- `o_LED_Result`, out, `N`: registered result.
- `o_overflow_Flag`, out, 1: registered signed overflow.
- `o_zero_Flag`, out, 1: registered, set when result is 0.
- `o_valid`, out, 1: one-cycle pulse when the result register updates.

## Operation
- Each button passes through a `SYNC_STAGES` flop chain, then a rising-edge detector. Exactly one load pulse is produced per press. A held button produces no repeats.
- On a load pulse, the matching register captures its switch field. Operand A and B registers are `N` bits; the Op register is `NSel` bits.
- Any load pulse sets an internal `dirty` bit for one cycle. On the next edge the result, flags and `o_valid` update from the already-updated registers.
- Opcodes, with other bits compared exactly:
  - ADD `6'b100000`, signed.
  - SUB `6'b100010`.
  - AND `6'b100100`.
  - OR `6'b100101`.
  - XOR `6'b100110`.
  - NOR `6'b100111`.
  - SRA `6'b000011`: A arithmetically shifted right by `B[$clog2(N)-1:0]`.
  - SRL `6'b000010`: logical shift.
- Unknown opcode: result is 0, overflow is 0, zero flag is 1.
- Arithmetic is `N`-bit two's complement; the result wraps modulo 2^N.
- Overflow is computed only for ADD/SUB. It is set when the operand signs match the expected sign pattern and the result sign differs. For all other opcodes it is 0.
- Simultaneous A/B/Op pulses in the same cycle: all registers load, and one result update follows.
- Simultaneous Acc and A pulses: the switch load wins.
- Reset, asynchronous and at any time including mid-press:
  - All registers, flags, `o_valid`, synchroniser flops and edge-history flops go to 0.
  - The Op register resets to ADD.
  - Because edge history is cleared, a button still held at reset release registers as a fresh press after synchronisation.

## Timing
- Raw button high before clock edge k gives a load pulse in cycle k+`SYNC_STAGES`-1, with the register updated at edge k+`SYNC_STAGES`.
- Result, flags and `o_valid` update one edge later. Total latency is `SYNC_STAGES`+1 edges; 3 with the default.
- Back-to-back presses separated by at least 2 cycles low are each detected.
- Outputs are constant between updates. There are no combinational paths from any input to any output.

## Configuration
- `ALU_ACCUM_EN` defined:
  - `i_button_Acc` exists with its own synchroniser.
  - Its pulse loads A ← current result, then triggers a result update. Repeated presses chain the operation, e.g. running sum A+B.
- `ALU_ACCUM_EN` undefined:
  - The port and its logic are absent.
  - A changes only from switches.

## Structure
- Package `alu_pkg`:
  - Opcode localparams `OP_ADD`…`OP_SRL`.
  - `OP_RESET` = `OP_ADD`.
  - Constant `MAX_SW` = 16.
- Sub-module `button_edge`, parameterised by `SYNC_STAGES`. It contains the synchroniser plus rising-edge detector with async active-low reset. It is instantiated three times, or four with accumulate.
- The ALU datapath is a combinational function on the registered operands inside the top, followed by the result/flag register.

## Test plan
- Reset: hold `i_reset`=0 with random inputs → all outputs 0, result 0, zero flag 0. After release with no presses, outputs stay 0.
- ADD overflow, N=5: A=`5'b01111`, B=`5'b00001`, Op=ADD → result `5'b10000`, ovf=1, zero=0. `o_valid` pulses exactly 3 edges after the last press.
- SUB to zero: A=9, B=9, Op=SUB → result 0, zero=1, ovf=0. Then Op=`6'b111111` → result 0, zero=1, ovf=0.
- SRA/SRL: A=`5'b10100`, B=2 → SRA gives `5'b11101`; SRL gives `5'b00101`.
- Held button and simultaneous presses: hold A for 50 cycles → one `o_valid` pulse. Press A+B in the same cycle → one update using both new values.
- `ALU_ACCUM_EN`: A=1, B=1, ADD, then press Acc 3 times → results 3, 4, 5. Press Acc and A together with switch A=7 → A=7, result 8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and limits for the switch-driven ALU block.
package alu_pkg;

  localparam int MAX_SW = 16;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [5:0] OP_RESET = OP_ADD;

endpackage

// File: rtl/button_edge.sv
// Raw push-button synchroniser followed by a rising-edge detector; one pulse per press.
module button_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Cleared history makes a button held through reset count as a fresh press.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_accum_top.sv
// Board-level ALU: button-loaded operand/opcode registers feeding a registered result and flags.
// Optional accumulate button (copies the result into A) is enabled by defining ALU_ACCUM_EN.
module alu_accum_top
  import alu_pkg::*;
#(
  parameter int N           = 5,
  parameter int NSel        = 6,
  parameter int N_SW        = (2 * N) + NSel,
  parameter int SYNC_STAGES = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N_SW-1:0] i_switches,
  input  logic            i_button_A,
  input  logic            i_button_B,
  input  logic            i_button_Op,
`ifdef ALU_ACCUM_EN
  input  logic            i_button_Acc,
`endif
  output logic [N-1:0]    o_LED_Result,
  output logic            o_overflow_Flag,
  output logic            o_zero_Flag,
  output logic            o_valid
);

  localparam int SH_W = $clog2(N);

  if (N_SW > MAX_SW) begin : g_bad_sw
    $error("alu_accum_top: N_SW exceeds MAX_SW");
  end
  if (N < 2 || N > 16 || NSel < 6 || SYNC_STAGES < 2 || N_SW <= 2 * N) begin : g_bad_param
    $error("alu_accum_top: parameter out of range");
  end

  logic load_a, load_b, load_op, any_load;
  logic [N-1:0]    a_q, b_q, result_q;
  logic [NSel-1:0] op_q;
  logic            dirty_q, ovf_q, zero_q, valid_q;
  logic [N-1:0]    alu_res;
  logic            alu_ovf;
  logic [SH_W-1:0] shamt;

  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_a
    (.clk(i_clock), .rst_n(i_reset), .button(i_button_A),  .pulse(load_a));
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_b
    (.clk(i_clock), .rst_n(i_reset), .button(i_button_B),  .pulse(load_b));
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_op
    (.clk(i_clock), .rst_n(i_reset), .button(i_button_Op), .pulse(load_op));

`ifdef ALU_ACCUM_EN
  logic load_acc;
  button_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_acc
    (.clk(i_clock), .rst_n(i_reset), .button(i_button_Acc), .pulse(load_acc));
  assign any_load = load_a | load_b | load_op | load_acc;
`else
  assign any_load = load_a | load_b | load_op;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= NSel'(OP_RESET);
      dirty_q <= 1'b0;
    end else begin
      // A switch load takes priority over a simultaneous accumulate.
      if (load_a) a_q <= i_switches[N-1:0];
`ifdef ALU_ACCUM_EN
      else if (load_acc) a_q <= result_q;
`endif
      if (load_b)  b_q  <= i_switches[2*N-1:N];
      if (load_op) op_q <= NSel'(i_switches[N_SW-1:2*N]);
      dirty_q <= any_load;
    end
  end

  assign shamt = b_q[SH_W-1:0];

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      NSel'(OP_ADD): begin
        alu_res = a_q + b_q;
        alu_ovf = (a_q[N-1] == b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      NSel'(OP_SUB): begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q[N-1] != b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      NSel'(OP_AND): alu_res = a_q & b_q;
      NSel'(OP_OR):  alu_res = a_q | b_q;
      NSel'(OP_XOR): alu_res = a_q ^ b_q;
      NSel'(OP_NOR): alu_res = ~(a_q | b_q);
      NSel'(OP_SRA): alu_res = N'($signed(a_q) >>> shamt);
      NSel'(OP_SRL): alu_res = a_q >> shamt;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= dirty_q;
      if (dirty_q) begin
        result_q <= alu_res;
        ovf_q    <= alu_ovf;
        zero_q   <= (alu_res == '0);
      end
    end
  end

  assign o_LED_Result    = result_q;
  assign o_overflow_Flag = ovf_q;
  assign o_zero_Flag     = zero_q;
  assign o_valid         = valid_q;

endmodule
